// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and master indices for mem_port_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam int M_PROC = 0;
  localparam int M_LOAD = 1;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: one-hot winner of two requests; fixed master-0 priority under ARB_FIXED_PRIO_EN
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifndef ARB_FIXED_PRIO_EN
  input  logic       ptr,
`endif
  output logic [1:0] win
);
`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win         = '0;
    win[M_PROC] = req[M_PROC];
    win[M_LOAD] = req[M_LOAD] & ~req[M_PROC];
  end
`else
  // ptr names the preferred master: 0 = processor, 1 = loader
  always_comb begin
    win         = '0;
    win[M_PROC] = req[M_PROC] & (~req[M_LOAD] | ~ptr);
    win[M_LOAD] = req[M_LOAD] & (~req[M_PROC] | ptr);
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master sequencer for a single-port sync RAM; ARB_FIXED_PRIO_EN selects fixed priority
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] m_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wren,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);
  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          wr_q, wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d, ack_q, ack_d, pick;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic          wren_q, wren_d, busy_q;
`ifndef ARB_FIXED_PRIO_EN
  logic          ptr_q, ptr_d;
`endif

  arb_rr_pick u_pick (
    .req ({m1_req, m0_req}),
`ifndef ARB_FIXED_PRIO_EN
    .ptr (ptr_q),
`endif
    .win (pick)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = '0;
    wren_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: if (|pick) begin
        state_d = ACCESS;
        win_d   = pick[M_LOAD];
        wr_d    = win_d ? m1_wr : m0_wr;
        addr_d  = win_d ? m1_addr : m0_addr;
        wdata_d = win_d ? m1_wdata : m0_wdata;
        wren_d  = wr_d;
        gnt_d   = pick;
      end
      ACCESS: begin
        state_d = MEM_LAT == 1 ? RESP : WAIT;
        cnt_d   = 2'(MEM_LAT - 2);
      end
      WAIT: begin
        state_d = cnt_q == 2'd0 ? RESP : WAIT;
        cnt_d   = cnt_q - 2'd1;
      end
      default: begin
        state_d = IDLE;
        rdata_d = wr_q ? rdata_q : mem_q;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d   = ~ptr_q;
`endif
      end
    endcase
    ack_d = state_d == RESP ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      wren_q  <= wren_d;
      busy_q  <= state_d != IDLE;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign m0_gnt    = gnt_q[M_PROC];
  assign m1_gnt    = gnt_q[M_LOAD];
  assign m0_ack    = ack_q[M_PROC];
  assign m1_ack    = ack_q[M_LOAD];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  // A reset landing in the ACCESS cycle must not let the RAM commit the write
  assign mem_wren  = wren_q & Resetn;
  // RAM data only arrives in the RESP cycle, so it is forwarded alongside ack and held afterwards
  assign m_rdata   = state_q == RESP && !wr_q ? mem_q : rdata_q;
endmodule
